// File: rtl/writeback_unit.sv
// writeback_unit: retire stage behind the MSP430 function unit. It commits results to
// the register file or data memory and merges Z/V/N/C into SR.
`default_nettype none

module writeback_unit #(
    parameter int SR_REG = 2,
    parameter int CG_REG = 3,
    parameter int PC_REG = 0
) (
    input  logic        MCLK,
    input  logic        RESETn,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [15:0] IW,
    input  logic [15:0] result,
    input  logic [3:0]  flags_in,
    input  logic [15:0] sr_in,
    input  logic [3:0]  dst_reg,
    input  logic        dst_is_mem,
    input  logic [15:0] dst_addr,
    output logic        rf_we,
    output logic [3:0]  rf_addr,
    output logic [15:0] rf_data,
    output logic        sr_we,
    output logic [15:0] sr_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic        mem_ready,
    output logic        wb_done,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_MEM  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:6] iw_q;
    logic [15:0] result_q;
    logic [3:0]  flags_q;
    logic [15:0] sr_q;
    logic [3:0]  dst_reg_q;
    logic        dst_mem_q;
    logic [15:0] dst_addr_q;

    always_ff @(posedge MCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge MCLK or negedge RESETn) begin
        if (!RESETn) begin
            iw_q       <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            sr_q       <= '0;
            dst_reg_q  <= '0;
            dst_mem_q  <= 1'b0;
            dst_addr_q <= '0;
        end else if (state_q == S_IDLE && ex_valid) begin
            iw_q       <= IW[15:6];
            result_q   <= result;
            flags_q    <= flags_in;
            sr_q       <= sr_in;
            dst_reg_q  <= dst_reg;
            dst_mem_q  <= dst_is_mem;
            dst_addr_q <= dst_addr;
        end
    end

    // Instruction class decode from the latched IW
    logic is_jump, is_fmt1, is_fmt2, is_byte;
    logic flag_op, suppress, dst_only, illegal_op;
    logic writes, reg_wr, mem_wr, sr_override;

    assign is_jump = (iw_q[15:13] == 3'b001);
    assign is_fmt1 = (iw_q[15:14] != 2'b00);
    assign is_fmt2 = (iw_q[15:10] == 6'b000100);
    assign is_byte = iw_q[6];

    always_comb begin
        flag_op  = 1'b0;
        suppress = 1'b0;
        dst_only = 1'b0;
        if (is_fmt1) begin
            case (iw_q[15:12])
                4'h4, 4'hC, 4'hD:                         dst_only = 1'b1;
                4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE, 4'hF: flag_op  = 1'b1;
                4'h9, 4'hB: begin
                    flag_op  = 1'b1;
                    suppress = 1'b1;
                end
                default: ;
            endcase
        end else if (is_fmt2) begin
            case (iw_q[9:7])
                3'b000, 3'b010: flag_op  = 1'b1;        // RRC, RRA
                3'b011:         flag_op  = !is_byte;    // SXT has no byte form
                3'b001:         dst_only = !is_byte;    // SWPB
                3'b100:         dst_only = 1'b1;        // PUSH
                3'b101:         dst_only = !is_byte;    // CALL
                default: ;
            endcase
        end
    end

    assign illegal_op  = !(is_jump || flag_op || dst_only);
    assign writes      = !is_jump && (dst_only || (flag_op && !suppress));
    assign mem_wr      = writes && dst_mem_q;
    assign reg_wr      = writes && !dst_mem_q;
    assign sr_override = flag_op && reg_wr && (dst_reg_q == 4'(SR_REG));

    logic [15:0] sr_merged, mem_addr_w, mem_wdata_w;
    logic [1:0]  mem_be_w;

    // flags_q is {Z,V,N,C}; SR keeps C at bit 0, Z at 1, N at 2, V at 8
    always_comb begin
        sr_merged    = sr_q;
        sr_merged[0] = flags_q[0];
        sr_merged[1] = flags_q[3];
        sr_merged[2] = flags_q[1];
        sr_merged[8] = flags_q[2];
    end

    assign mem_addr_w  = is_byte ? dst_addr_q : {dst_addr_q[15:1], 1'b0};
    assign mem_wdata_w = is_byte ? {result_q[7:0], result_q[7:0]} : result_q;
    assign mem_be_w    = is_byte ? (dst_addr_q[0] ? 2'b10 : 2'b01) : 2'b11;

    always_comb begin
        state_d   = state_q;
        ex_ready  = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_data   = '0;
        sr_we     = 1'b0;
        sr_data   = '0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        wb_done   = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid) state_d = S_WB;
            end
            S_WB: begin
                rf_we   = is_jump || (reg_wr && (dst_reg_q != 4'(CG_REG)));
                rf_addr = is_jump ? 4'(PC_REG) : dst_reg_q;
                rf_data = result_q;
                sr_we   = flag_op;
                sr_data = sr_override ? result_q : sr_merged;
                illegal = illegal_op;
                if (mem_wr) begin
                    // Request goes out now, but the handshake only completes in MEM
                    mem_req   = 1'b1;
                    mem_addr  = mem_addr_w;
                    mem_wdata = mem_wdata_w;
                    mem_be    = mem_be_w;
                    state_d   = S_MEM;
                end else begin
                    wb_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_addr  = mem_addr_w;
                mem_wdata = mem_wdata_w;
                mem_be    = mem_be_w;
                if (mem_ready) begin
                    wb_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven bench for writeback_unit with a queue of expected retirements.
`default_nettype none

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [15:0] iw, result, sr_in, dst_addr;
    logic [3:0]  flags_in, dst_reg;
    logic        dst_is_mem;
    logic        rf_we, sr_we, mem_req, mem_ready, wb_done, illegal;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data, sr_data, mem_addr, mem_wdata;
    logic [1:0]  mem_be;

    writeback_unit dut (
        .MCLK(clk), .RESETn(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .IW(iw), .result(result), .flags_in(flags_in), .sr_in(sr_in),
        .dst_reg(dst_reg), .dst_is_mem(dst_is_mem), .dst_addr(dst_addr),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .sr_we(sr_we), .sr_data(sr_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .wb_done(wb_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] iw;
        logic [15:0] result;
        logic [3:0]  flags;
        logic [15:0] sr_in;
        logic [3:0]  dst_reg;
        logic        dst_mem;
        logic [15:0] dst_addr;
        logic        e_rf_we;
        logic [3:0]  e_rf_addr;
        logic [15:0] e_rf_data;
        logic        e_sr_we;
        logic [15:0] e_sr_data;
        logic        e_ill;
        logic        e_mem;
        logic [15:0] e_maddr;
        logic [15:0] e_mwdata;
        logic [1:0]  e_be;
        int          waits;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[15];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic [15:0] i_iw, input logic [15:0] i_res, input logic [3:0] i_fl,
        input logic [15:0] i_sr, input logic [3:0] i_dr, input logic i_dm,
        input logic [15:0] i_da, input logic rfw, input logic [3:0] rfa,
        input logic [15:0] rfd, input logic srw, input logic [15:0] srd,
        input logic ill, input logic mw, input logic [15:0] ma, input logic [15:0] md,
        input logic [1:0] be, input int w);
        vec_t v;
        v.iw = i_iw; v.result = i_res; v.flags = i_fl; v.sr_in = i_sr;
        v.dst_reg = i_dr; v.dst_mem = i_dm; v.dst_addr = i_da;
        v.e_rf_we = rfw; v.e_rf_addr = rfa; v.e_rf_data = rfd;
        v.e_sr_we = srw; v.e_sr_data = srd; v.e_ill = ill;
        v.e_mem = mw; v.e_maddr = ma; v.e_mwdata = md; v.e_be = be; v.waits = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        iw = v.iw; result = v.result; flags_in = v.flags; sr_in = v.sr_in;
        dst_reg = v.dst_reg; dst_is_mem = v.dst_mem; dst_addr = v.dst_addr;
        ex_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        mem_ready = 1'b0;
        exp_q.push_back(v);
        #1 chk("ex_ready_idle", ex_ready, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        chk("rf_we", rf_we, e.e_rf_we);
        if (e.e_rf_we) begin
            chk("rf_addr", rf_addr, e.e_rf_addr);
            chk("rf_data", rf_data, e.e_rf_data);
        end
        chk("sr_we", sr_we, e.e_sr_we);
        if (e.e_sr_we) chk("sr_data", sr_data, e.e_sr_data);
        chk("illegal", illegal, e.e_ill);
        chk("mem_req_wb", mem_req, e.e_mem);
        chk("wb_done_wb", wb_done, !e.e_mem);
        chk("ex_ready_wb", ex_ready, 0);
        if (e.e_mem) begin
            chk("mem_addr", mem_addr, e.e_maddr);
            chk("mem_wdata", mem_wdata, e.e_mwdata);
            chk("mem_be", mem_be, e.e_be);
            for (int i = 1; i < e.waits; i++) begin
                @(negedge clk);
                #1;
                chk("mem_req_wait", mem_req, 1);
                chk("wb_done_wait", wb_done, 0);
                chk("sr_we_wait", sr_we, 0);
                chk("mem_addr_wait", mem_addr, e.e_maddr);
            end
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            chk("wb_done_mem", wb_done, 1);
            chk("mem_req_mem", mem_req, 1);
            chk("mem_wdata_mem", mem_wdata, e.e_mwdata);
            @(negedge clk);
            mem_ready = 1'b0;
        end else begin
            @(negedge clk);
        end
        #1;
        chk("ex_ready_after", ex_ready, 1);
        chk("wb_done_after", wb_done, 0);
        chk("mem_req_after", mem_req, 0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        iw = '0; result = '0; flags_in = '0; sr_in = '0;
        dst_reg = '0; dst_is_mem = 1'b0; dst_addr = '0;

        //            IW       result   ZVNC     sr_in    dr  mem da       rfw rfa rfd      srw srd      ill mw addr     wdata    be    w
        tbl[0]  = mk(16'h5405, 16'h0000, 4'b1001, 16'h0000, 5, 0, 16'h0000, 1, 5, 16'h0000, 1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[1]  = mk(16'h9407, 16'h1234, 4'b0010, 16'h0101, 7, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[2]  = mk(16'h4440, 16'h00A5, 4'b0000, 16'h0000, 0, 1, 16'h0201, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0201, 16'hA5A5, 2'b10, 3);
        tbl[3]  = mk(16'h3C00, 16'hC010, 4'b1111, 16'h0000, 9, 1, 16'h0400, 1, 0, 16'hC010, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[4]  = mk(16'hE402, 16'h0108, 4'b1111, 16'hFFFF, 2, 0, 16'h0000, 1, 2, 16'h0108, 1, 16'h0108, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[5]  = mk(16'h5403, 16'h0055, 4'b0100, 16'h00F0, 3, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h01F0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[6]  = mk(16'h1300, 16'h1111, 4'b1111, 16'h0000, 4, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[7]  = mk(16'h0000, 16'h2222, 4'b1111, 16'h0000, 4, 1, 16'h0300, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[8]  = mk(16'h1006, 16'h8000, 4'b0011, 16'h0008, 6, 0, 16'h0000, 1, 6, 16'h8000, 1, 16'h000D, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[9]  = mk(16'hB40A, 16'h0000, 4'b1000, 16'h0107, 10, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[10] = mk(16'hC40B, 16'hBEEF, 4'b1111, 16'h0000, 11, 0, 16'h0000, 1, 11, 16'hBEEF, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[11] = mk(16'h1204, 16'h1234, 4'b0000, 16'h0000, 1, 1, 16'h0203, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0202, 16'h1234, 2'b11, 1);
        tbl[12] = mk(16'h5444, 16'h00FF, 4'b0001, 16'h0000, 0, 1, 16'h0300, 0, 0, 16'h0000, 1, 16'h0001, 0, 1, 16'h0300, 16'hFFFF, 2'b01, 2);
        tbl[13] = mk(16'h4403, 16'h7777, 4'b1111, 16'h0000, 3, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);
        tbl[14] = mk(16'h9480, 16'h3333, 4'b0001, 16'h0000, 0, 1, 16'h0500, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 2'b00, 0);

        // Reset state
        #12;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_done", wb_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        // mem_ready high during WB must not complete the write
        @(negedge clk);
        drive(tbl[11]);
        mem_ready = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("early_ready_wb_done", wb_done, 0);
        chk("early_ready_mem_req", mem_req, 1);
        @(negedge clk);
        #1;
        chk("early_ready_done_mem", wb_done, 1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 chk("early_ready_idle", ex_ready, 1);

        // ex_valid while busy is ignored
        @(negedge clk);
        drive(tbl[2]);
        @(negedge clk);
        dst_addr = 16'h0FF0;
        result = 16'h0099;
        @(negedge clk);
        #1;
        chk("busy_mem_addr", mem_addr, 16'h0201);
        chk("busy_mem_wdata", mem_wdata, 16'hA5A5);
        chk("busy_ex_ready", ex_ready, 0);
        mem_ready = 1'b1;
        ex_valid = 1'b0;
        #1 chk("busy_wb_done", wb_done, 1);
        @(negedge clk);
        mem_ready = 1'b0;

        // Asynchronous reset in the middle of a memory request
        @(negedge clk);
        drive(tbl[12]);
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        #1 chk("pre_rst_mem_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_ex_ready", ex_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_wb_done", wb_done, 0);
            chk("post_rst_mem_req", mem_req, 0);
            chk("post_rst_ex_ready", ex_ready, 1);
        end
        mem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Retire stage directly downstream of the MSP430 function unit.
- Accepts one executed instruction per handshake: IW, 16-bit result and new Z/V/N/C flags.
- Commits the result to the register file or to data memory, and merges the flags into SR.
- Provides back-pressure while a memory write is outstanding.

Parameters:
- SR_REG, 2, register-file index of the status register.
- CG_REG, 3, register-file index of the constant generator; writes to it are discarded.
- PC_REG, 0, register-file index of the program counter; jump results go here.

Ports:
- MCLK  in  1  system clock; all state changes on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  unit can accept an instruction.
- IW  in  16  instruction word.
- result  in  16  function-unit result; upper byte is already 0 for byte ops.
- flags_in  in  4  {Z,V,N,C} from the function unit.
- sr_in  in  16  current SR contents.
- dst_reg  in  4  destination register index.
- dst_is_mem  in  1  1 = memory destination.
- dst_addr  in  16  memory destination address.
- rf_we  out  1  register-file write strobe.
- rf_addr  out  4  register-file write index.
- rf_data  out  16  register-file write data.
- sr_we  out  1  SR write strobe.
- sr_data  out  16  SR write data.
- mem_req  out  1  memory write request.
- mem_addr  out  16  memory write address.
- mem_wdata  out  16  memory write data.
- mem_be  out  2  byte enables {hi,lo}.
- mem_ready  in  1  memory accepted the write.
- wb_done  out  1  one-cycle pulse when the instruction retires.
- illegal  out  1  one-cycle pulse when an unsupported IW retires.

Behaviour:
- Reset:
  - RESETn low → state IDLE immediately (asynchronous).
  - All outputs 0 except ex_ready=1.
  - mem_req drops asynchronously, even mid-request.
  - The in-flight instruction is lost.
- States: IDLE, WB, MEM.
  - IDLE: ex_ready=1. When ex_valid&ex_ready, latch all inputs and go to WB.
  - WB (one cycle, ex_ready=0): drive rf_*/sr_* strobes. If this is a memory write, go to MEM; otherwise pulse wb_done and go to IDLE.
  - MEM: hold mem_req=1 and mem_addr/wdata/be stable until mem_ready is sampled 1. In that same cycle, pulse wb_done and go to IDLE; mem_req is 0 from the next cycle.
- Latency:
  - Register destination: accepted at edge n; rf_we and wb_done high during cycle n+1; ex_ready high again at n+2.
  - Memory destination: mem_req first high in cycle n+1.
- Instruction classes, decoded from the latched IW:
  - Flag-updating: RRC(B), RRA(B), SXT, ADD(B), ADDC(B), SUB(B), SUBC(B), CMP(B), DADD(B), AND(B), BIT(B), XOR(B). sr_we=1 in WB; sr_data = sr_in with bits C(0), Z(1), N(2), V(8) replaced by flags_in.
  - Write-suppressed: CMP(B), BIT(B). No rf or memory write; flags only.
  - Jumps (IW[15:13]=001): rf_we=1, rf_addr=PC_REG, rf_data=result. dst_reg and dst_is_mem are ignored; no flags.
  - MOV(B), BIC(B), BIS(B), SWPB, PUSH(B), CALL: destination write only, no flags.
  - RETI or any other opcode: no writes; illegal and wb_done pulse in WB.
- Register write:
  - rf_addr=dst_reg, rf_data=result.
  - dst_reg==CG_REG → rf_we held 0.
  - dst_reg==SR_REG on a flag-updating op → the register write wins: sr_we=1 with sr_data=result (no merge), rf_we=1.
- Memory write:
  - Word op: mem_addr={dst_addr[15:1],0}, mem_be=11, mem_wdata=result.
  - Byte op (IW[6]=1): mem_addr=dst_addr, mem_wdata={result[7:0],result[7:0]}, mem_be=10 if dst_addr[0] else 01.
  - The flag write (sr_we) occurs in WB, before the memory handshake completes.
- mem_ready high while not in MEM: ignored.
- ex_valid while busy: ignored. Upstream must hold the instruction until ex_ready.

Test Plan:
- ADD to R5, result=0x0000, flags_in=Z1V0N0C1, sr_in=0x0000 → cycle n+1: rf_we=1, rf_addr=5, rf_data=0, sr_we=1, sr_data=0x0003, wb_done=1; ex_ready=1 at n+2.
- CMP with dst_reg=7, flags_in=N=1 only, sr_in=0x0101 → rf_we=0, sr_data=0x0004, wb_done=1.
- MOV.B to memory 0x0201, result=0x00A5, mem_ready held low 3 cycles → mem_req high 4 cycles, mem_addr=0x0201, mem_wdata=0xA5A5, mem_be=10, sr_we=0, wb_done in the mem_ready cycle.
- JMP with result=0xC010, dst_reg=9, dst_is_mem=1 → rf_we=1, rf_addr=0, rf_data=0xC010, mem_req=0, sr_we=0.
- XOR with dst_reg=2, result=0x0108 → sr_we=1, sr_data=0x0108 (no merge); ADD to R3 → rf_we=0, sr_we=1.
- RESETn low during MEM with mem_req=1 → mem_req=0 without a clock edge; after release: IDLE, ex_ready=1, no wb_done.
